// File: rtl/tick_counter.sv
// tick_counter: programmable prescaler feeding a modulo up/down counter.
// A registered tick advances q; wrap pulses on the wrapping advance.
module tick_counter #(
  parameter int DIV_W   = 28,
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             up,
  input  logic [CNT_W-1:0] max_val,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] q,
  output logic             tick,
  output logic             wrap,
  output logic             tc
);

  logic [DIV_W-1:0] pre_cnt;
  logic [CNT_W-1:0] load_clip;

  if (64'(DIV_RST) >= (64'd1 << DIV_W)) begin : g_div_rst_range
    $error("DIV_RST does not fit in DIV_W bits");
  end

  assign load_clip = (load_val > max_val) ? max_val : load_val;

  // Terminal count depends on direction, so it stays combinational.
  assign tc = (up && (q == max_val)) || (!up && (q == '0));

  // Prescaler: >= compare lets a lowered div_val tick immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (load) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (en) begin
      if (pre_cnt >= div_val) begin
        pre_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        pre_cnt <= pre_cnt + DIV_W'(1);
        tick    <= 1'b0;
      end
    end
  end

  // Counter advances on the registered tick; wrap marks the wrap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_clip;
      wrap <= 1'b0;
    end else if (en && tick) begin
      if (up) begin
        if (q >= max_val) begin
          q    <= '0;
          wrap <= 1'b1;
        end else begin
          q    <= q + CNT_W'(1);
          wrap <= 1'b0;
        end
      end else begin
        if (q == '0) begin
          q    <= max_val;
          wrap <= 1'b1;
        end else begin
          q    <= q - CNT_W'(1);
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_counter.sv
// tb_tick_counter: directed steps then random traffic, each cycle
// compared against a behavioural model of the prescaler and counter.
module tb_tick_counter;

  localparam int DIV_W = 28;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             up;
  logic [CNT_W-1:0] max_val;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] q;
  logic             tick;
  logic             wrap;
  logic             tc;

  int passed = 0;
  int total  = 0;

  int m_pre  = 0;
  int m_q    = 0;
  int m_tick = 0;
  int m_wrap = 0;

  tick_counter #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .up(up),
    .max_val(max_val), .load(load), .load_val(load_val),
    .q(q), .tick(tick), .wrap(wrap), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int m_tc();
    return ((up && m_q == int'(max_val)) || (!up && m_q == 0)) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".q"}, int'(q), m_q);
    chk({tag, ".tick"}, int'(tick), m_tick);
    chk({tag, ".wrap"}, int'(wrap), m_wrap);
    chk({tag, ".tc"}, int'(tc), m_tc());
  endtask

  task automatic m_reset();
    m_pre = 0; m_q = 0; m_tick = 0; m_wrap = 0;
  endtask

  // One clock edge seen from the rules: who wins, then what changes.
  task automatic m_edge();
    int mx;
    int adv;
    mx = int'(max_val);
    if (rst) begin
      m_reset();
    end else if (load) begin
      m_q = (int'(load_val) < mx) ? int'(load_val) : mx;
      m_pre = 0; m_tick = 0; m_wrap = 0;
    end else if (en) begin
      adv = m_tick;
      m_wrap = 0;
      if (m_pre >= int'(div_val)) begin
        m_pre = 0; m_tick = 1;
      end else begin
        m_pre++; m_tick = 0;
      end
      if (adv == 1) begin
        if (up) begin
          if (m_q >= mx) begin m_q = 0; m_wrap = 1; end
          else m_q++;
        end else begin
          if (m_q == 0) begin m_q = mx; m_wrap = 1; end
          else m_q--;
        end
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    m_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_val = '0; up = 1'b1;
    max_val = 8'd255; load = 1'b0; load_val = '0;
    m_reset();
    #2;
    check_all("reset");
    step("reset_clk");
    rst = 1'b0;

    // q=5, pre=2, then async reset between edges
    div_val = 28'd3; en = 1'b1; load = 1'b1; load_val = 8'd5;
    step("pre_load");
    load = 1'b0;
    step("pre_a");
    step("pre_b");
    chk("mid_q5", int'(q), 5);
    rst = 1'b1;
    #2;
    m_reset();
    check_all("async_rst");
    step("async_rst_hold");
    rst = 1'b0;

    // div_val=3: tick every 4th cycle, 4 ticks -> q reaches 3
    for (int i = 0; i < 16; i++) step("div3");
    chk("div3_q", int'(q), 3);

    // count up through max_val=9 with div_val=0
    div_val = '0; max_val = 8'd9; load = 1'b1; load_val = 8'd8;
    step("up_load");
    load = 1'b0;
    for (int i = 0; i < 4; i++) step("up_wrap");

    // count down through 0
    up = 1'b0; load = 1'b1; load_val = 8'd1;
    step("dn_load");
    load = 1'b0;
    for (int i = 0; i < 4; i++) step("dn_wrap");

    // load clips to max_val with en low
    en = 1'b0; max_val = 8'd15; load = 1'b1; load_val = 8'd20;
    step("clip");
    chk("clip_q15", int'(q), 15);
    load = 1'b0;

    // load beats a pending tick
    en = 1'b1; up = 1'b1; div_val = '0;
    step("lt_a");
    load = 1'b1; load_val = 8'd3;
    step("lt_load");
    chk("lt_q3", int'(q), 3);
    load = 1'b0;

    // pre_cnt=8 with div 10, drop div to 5
    div_val = 28'd10; max_val = 8'd255; load = 1'b1; load_val = 8'd0;
    step("dv_load");
    load = 1'b0;
    for (int i = 0; i < 8; i++) step("dv_run");
    div_val = 28'd5;
    step("dv_drop");
    chk("dv_tick", int'(tick), 1);
    for (int i = 0; i < 13; i++) step("dv_p6");

    // en low for 7 cycles freezes everything
    en = 1'b0;
    for (int i = 0; i < 7; i++) step("hold");
    en = 1'b1;
    for (int i = 0; i < 8; i++) step("resume");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 24) == 0);
      load_val = CNT_W'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      if ($urandom_range(0, 31) == 0) div_val = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 31) == 0)
        max_val = CNT_W'($urandom_range(0, 1) ? $urandom_range(0, 12)
                                              : $urandom_range(0, 255));
      step("rand");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
